// File: rtl/lookup_pkg.sv
// -----------------------------------------------------------------------------
// lookup_pkg
// Shared definitions for the MAC lookup arbiter:
//   - check_id field positions ({seq[1:0], req[1:0]})
//   - seek_flag encodings returned by the forwarding lookup
//   - per-requester tracker state encoding
//   - default lookup timeout in cycles
// -----------------------------------------------------------------------------
package lookup_pkg;

    // check_id = {seq, req}
    localparam int SEQ_MSB = 3;
    localparam int SEQ_LSB = 2;
    localparam int REQ_MSB = 1;
    localparam int REQ_LSB = 0;

    // Cycles a lookup may stay pending before a timeout response (>= 3).
    localparam logic [15:0] P_TIMEOUT_DEFAULT = 16'd64;

    typedef enum logic [1:0] {
        LOCAL_NONLOCAL = 2'd0,
        CROSSBAR       = 2'd1,
        TWO_HOP        = 2'd2,
        VLB            = 2'd3
    } seek_flag_e;

    typedef enum logic {
        TRK_IDLE = 1'b0,
        TRK_PEND = 1'b1
    } trk_state_e;

endpackage

// File: rtl/lookup_req_tracker.sv
// -----------------------------------------------------------------------------
// lookup_req_tracker
// Tracks the single outstanding lookup of one requester: pending flag, 2-bit
// sequence number, timeout counter, and capture of the response returned to
// the requester (normal result or timeout).
//
// Optional feature (macro LKUP_ARB_STATS_EN): saturating accept and timeout
// counters, cleared only by reset.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_accept              this requester was granted this cycle
//   i_result_valid        lookup result strobe
//   i_check_id            {seq, req} tag of the returned result
//   i_outport/i_seek_flag lookup result payload
//   o_pending             lookup outstanding (registered)
//   o_seq                 current sequence number (used to tag the next issue)
//   o_rsp_valid           one-cycle response pulse
//   o_rsp_outport         captured outport (0 on timeout), holds between pulses
//   o_rsp_seek_flag       captured seek_flag (0 on timeout), holds between pulses
//   o_rsp_timeout         pulse qualifying o_rsp_valid as a timeout
//   o_stat_grant_cnt      (stats build) accepts
//   o_stat_timeout_cnt    (stats build) timeouts
// -----------------------------------------------------------------------------
module lookup_req_tracker
    import lookup_pkg::*;
#(
    parameter logic [1:0]  P_REQ_IDX = 2'd0,
    parameter logic [15:0] P_TIMEOUT = P_TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_accept,
    input  logic        i_result_valid,
    input  logic [3:0]  i_check_id,
    input  logic [2:0]  i_outport,
    input  logic [1:0]  i_seek_flag,
    output logic        o_pending,
    output logic [1:0]  o_seq,
    output logic        o_rsp_valid,
    output logic [2:0]  o_rsp_outport,
    output logic [1:0]  o_rsp_seek_flag,
    output logic        o_rsp_timeout
`ifdef LKUP_ARB_STATS_EN
    ,
    output logic [31:0] o_stat_grant_cnt,
    output logic [15:0] o_stat_timeout_cnt
`endif
);

    trk_state_e  r_state;
    trk_state_e  w_state_nxt;
    logic [15:0] r_cnt;
    logic [1:0]  r_seq;
    logic        r_rsp_valid;
    logic [2:0]  r_rsp_outport;
    logic [1:0]  r_rsp_seek_flag;
    logic        r_rsp_timeout;
    logic        w_match;
    logic        w_timeout;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_match     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            TRK_IDLE: begin
                if (i_accept) begin
                    w_state_nxt = TRK_PEND;
                end
            end
            TRK_PEND: begin
                // Results whose seq does not match are stale and ignored.
                w_match = i_result_valid
                        && (i_check_id[REQ_MSB:REQ_LSB] == P_REQ_IDX)
                        && (i_check_id[SEQ_MSB:SEQ_LSB] == r_seq);
                // A match in the timeout cycle wins over the timeout.
                w_timeout = !w_match && (r_cnt == P_TIMEOUT - 16'd1);
                if (w_match || w_timeout) begin
                    w_state_nxt = TRK_IDLE;
                end
            end
            default: w_state_nxt = TRK_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= TRK_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt           <= '0;
            r_seq           <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_outport   <= '0;
            r_rsp_seek_flag <= '0;
            r_rsp_timeout   <= 1'b0;
        end else begin
            r_rsp_valid   <= w_match | w_timeout;
            r_rsp_timeout <= w_timeout;

            if (i_accept) begin
                r_cnt <= '0;
            end else if ((r_state == TRK_PEND) && (r_cnt != P_TIMEOUT)) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_match) begin
                r_rsp_outport   <= i_outport;
                r_rsp_seek_flag <= i_seek_flag;
                r_seq           <= r_seq + 2'd1;
            end else if (w_timeout) begin
                r_rsp_outport   <= '0;
                r_rsp_seek_flag <= LOCAL_NONLOCAL;
                r_seq           <= r_seq + 2'd1;
            end
        end
    end

`ifdef LKUP_ARB_STATS_EN
    logic [31:0] r_grant_cnt;
    logic [15:0] r_timeout_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (i_accept && (r_grant_cnt != '1)) begin
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end
            if (w_timeout && (r_timeout_cnt != '1)) begin
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
        end
    end

    assign o_stat_grant_cnt   = r_grant_cnt;
    assign o_stat_timeout_cnt = r_timeout_cnt;
`endif

    assign o_pending       = (r_state == TRK_PEND);
    assign o_seq           = r_seq;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_outport   = r_rsp_outport;
    assign o_rsp_seek_flag = r_rsp_seek_flag;
    assign o_rsp_timeout   = r_rsp_timeout;

endmodule

// File: rtl/lookup_arbiter.sv
// -----------------------------------------------------------------------------
// lookup_arbiter
// Shares the single MAC lookup port of the forwarding module between four
// requesters. Grants round-robin among requesters that are valid and have no
// lookup outstanding, issues the lookup one cycle after the grant tagged with
// {seq, req}, and routes each tagged result (or a timeout) back to its owner.
//
// Optional feature (macro LKUP_ARB_STATS_EN): per-requester saturating accept
// (32-bit) and timeout (16-bit) counters on o_stat_grant_cnt/o_stat_timeout_cnt.
//
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_req_valid[4]     per-requester request, held until accepted
//   i_req_mac[192]     requester i MAC in bits [48*i +: 48]
//   o_req_ready[4]     combinational one-hot grant
//   o_rsp_valid[4]     per-requester response pulse
//   o_rsp_outport[12]  3 bits per requester
//   o_rsp_seek_flag[8] 2 bits per requester
//   o_rsp_timeout[4]   response is a timeout
//   o_check_mac/id/valid    lookup request to the forwarding module
//   i_outport/i_seek_flag/i_check_id/i_result_valid  lookup result
// -----------------------------------------------------------------------------
module lookup_arbiter
    import lookup_pkg::*;
#(
    parameter int          P_NUM_REQ = 4,
    parameter logic [15:0] P_TIMEOUT = P_TIMEOUT_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [P_NUM_REQ-1:0]     i_req_valid,
    input  logic [48*P_NUM_REQ-1:0]  i_req_mac,
    output logic [P_NUM_REQ-1:0]     o_req_ready,
    output logic [P_NUM_REQ-1:0]     o_rsp_valid,
    output logic [3*P_NUM_REQ-1:0]   o_rsp_outport,
    output logic [2*P_NUM_REQ-1:0]   o_rsp_seek_flag,
    output logic [P_NUM_REQ-1:0]     o_rsp_timeout,
    output logic [47:0]              o_check_mac,
    output logic [3:0]               o_check_id,
    output logic                     o_check_valid,
    input  logic [2:0]               i_outport,
    input  logic [1:0]               i_seek_flag,
    input  logic [3:0]               i_check_id,
    input  logic                     i_result_valid
`ifdef LKUP_ARB_STATS_EN
    ,
    output logic [32*P_NUM_REQ-1:0]  o_stat_grant_cnt,
    output logic [16*P_NUM_REQ-1:0]  o_stat_timeout_cnt
`endif
);

    logic [P_NUM_REQ-1:0] w_pending;
    logic [P_NUM_REQ-1:0] w_elig;
    logic [P_NUM_REQ-1:0] w_ready;
    logic [P_NUM_REQ-1:0] w_accept;
    logic [1:0]           w_seq     [P_NUM_REQ];
    logic [47:0]          w_req_mac [P_NUM_REQ];
    logic [1:0]           w_grant_idx;
    logic                 w_grant_any;

    logic [1:0]           r_rr_ptr;
    logic                 r_check_valid;
    logic [47:0]          r_check_mac;
    logic [3:0]           r_check_id;

    // Eligibility uses the registered pending flag, so a result clearing it
    // allows a new accept one cycle later at the earliest.
    assign w_elig   = i_req_valid & ~w_pending;
    assign w_accept = w_ready & i_req_valid;

    // Search rr_ptr, rr_ptr+1, ... (2-bit index wraps mod 4); first eligible wins.
    always_comb begin
        w_ready     = '0;
        w_grant_idx = r_rr_ptr;
        w_grant_any = 1'b0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            if (!w_grant_any && w_elig[r_rr_ptr + 2'(k)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = r_rr_ptr + 2'(k);
            end
        end
        w_ready[w_grant_idx] = w_grant_any;
    end

    // Issue register: one lookup per accept, tag taken from the owner's seq.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr      <= '0;
            r_check_valid <= 1'b0;
            r_check_mac   <= '0;
            r_check_id    <= '0;
        end else begin
            r_check_valid <= w_grant_any;
            if (w_grant_any) begin
                r_check_mac <= w_req_mac[w_grant_idx];
                r_check_id  <= {w_seq[w_grant_idx], w_grant_idx};
                r_rr_ptr    <= w_grant_idx + 2'd1;
            end
        end
    end

    for (genvar gi = 0; gi < P_NUM_REQ; gi++) begin : g_trk
        assign w_req_mac[gi] = i_req_mac[48*gi +: 48];

        lookup_req_tracker #(
            .P_REQ_IDX (2'(gi)),
            .P_TIMEOUT (P_TIMEOUT)
        ) u_trk (
            .i_clk              (i_clk),
            .i_rst_n            (i_rst_n),
            .i_accept           (w_accept[gi]),
            .i_result_valid     (i_result_valid),
            .i_check_id         (i_check_id),
            .i_outport          (i_outport),
            .i_seek_flag        (i_seek_flag),
            .o_pending          (w_pending[gi]),
            .o_seq              (w_seq[gi]),
            .o_rsp_valid        (o_rsp_valid[gi]),
            .o_rsp_outport      (o_rsp_outport[3*gi +: 3]),
            .o_rsp_seek_flag    (o_rsp_seek_flag[2*gi +: 2]),
            .o_rsp_timeout      (o_rsp_timeout[gi])
`ifdef LKUP_ARB_STATS_EN
            ,
            .o_stat_grant_cnt   (o_stat_grant_cnt[32*gi +: 32]),
            .o_stat_timeout_cnt (o_stat_timeout_cnt[16*gi +: 16])
`endif
        );
    end

    assign o_req_ready   = w_ready;
    assign o_check_valid = r_check_valid;
    assign o_check_mac   = r_check_mac;
    assign o_check_id    = r_check_id;

endmodule

// File: tb/tb_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lookup_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level model
// predicts grants, issued lookups and responses; expectations are queued with
// the cycle they are due and a separate monitor compares them to the DUT.
// -----------------------------------------------------------------------------
module tb_lookup_arbiter;

    localparam int P_TO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid_in;
    logic [191:0] req_mac_in;
    logic [3:0]   ready;
    logic [3:0]   rsp_valid;
    logic [11:0]  rsp_outport;
    logic [7:0]   rsp_seek;
    logic [3:0]   rsp_timeout;
    logic [47:0]  check_mac;
    logic [3:0]   check_id;
    logic         check_valid;
    logic [2:0]   result_op;
    logic [1:0]   result_sf;
    logic [3:0]   result_id;
    logic         result_valid;
`ifdef LKUP_ARB_STATS_EN
    logic [127:0] stat_grant;
    logic [63:0]  stat_timeout;
`endif

    lookup_arbiter dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid_in),
        .i_req_mac       (req_mac_in),
        .o_req_ready     (ready),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_outport   (rsp_outport),
        .o_rsp_seek_flag (rsp_seek),
        .o_rsp_timeout   (rsp_timeout),
        .o_check_mac     (check_mac),
        .o_check_id      (check_id),
        .o_check_valid   (check_valid),
        .i_outport       (result_op),
        .i_seek_flag     (result_sf),
        .i_check_id      (result_id),
        .i_result_valid  (result_valid)
`ifdef LKUP_ARB_STATS_EN
        ,
        .o_stat_grant_cnt   (stat_grant),
        .o_stat_timeout_cnt (stat_timeout)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [47:0] mac; logic [3:0] id; } chk_t;
    typedef struct { int due; int r; logic [2:0] op; logic [1:0] sf; logic to; } rsp_t;
    typedef struct { int at; logic [3:0] id; logic [2:0] op; logic [1:0] sf; } res_t;

    chk_t exp_chk[$];
    rsp_t exp_rsp[$];
    res_t sched[$];

    int n_vec = 0;
    int n_err = 0;

    // Requester-side stimulus state
    logic [3:0]  req_valid;
    logic [47:0] mac_of [4];
    bit          drop_mask [4];
    int          drop_pct = 0;

    // Reference model state
    bit          m_pend [4];
    logic [1:0]  m_seq [4];
    int          m_chk_cyc [4];
    int          m_rr;

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i]    = 1'b0;
            m_seq[i]     = 2'd0;
            m_chk_cyc[i] = 0;
        end
        m_rr = 0;
        exp_chk.delete();
        exp_rsp.delete();
    endtask

    function automatic bit sched_busy(int at);
        foreach (sched[k]) if (sched[k].at == at) return 1'b1;
        return 1'b0;
    endfunction

    task automatic inject(int at, logic [3:0] id, logic [2:0] op, logic [1:0] sf);
        sched.push_back('{at: at, id: id, op: op, sf: sf});
    endtask

    // One clock cycle: drive inputs, predict grant/match/timeout, queue expectations.
    task automatic step(output int g);
        int         hit;
        bit         matched;
        bit         timed;
        logic [3:0] exp_ready;
        int         idx;
        hit = -1;
        @(negedge clk);
        req_valid_in = req_valid;
        for (int i = 0; i < 4; i++) req_mac_in[48*i +: 48] = mac_of[i];
        for (int k = sched.size() - 1; k >= 0; k--) if (sched[k].at < cyc) sched.delete(k);
        foreach (sched[k]) if (hit < 0 && sched[k].at == cyc) hit = k;
        result_valid = 1'b0;
        result_id    = 4'($urandom);
        result_op    = 3'($urandom);
        result_sf    = 2'($urandom);
        if (hit >= 0) begin
            result_valid = 1'b1;
            result_id    = sched[hit].id;
            result_op    = sched[hit].op;
            result_sf    = sched[hit].sf;
            sched.delete(hit);
        end
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_rr + k) % 4;
            if (g < 0 && req_valid[idx] && !m_pend[idx]) g = idx;
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
        check("req_ready", 64'(ready), 64'(exp_ready));
        for (int r = 0; r < 4; r++) begin
            matched = result_valid && (result_id[1:0] == 2'(r)) && m_pend[r]
                      && (result_id[3:2] == m_seq[r]);
            timed   = m_pend[r] && ((cyc - m_chk_cyc[r]) == P_TO - 1) && !matched;
            if (matched) exp_rsp.push_back('{due: cyc + 1, r: r, op: result_op, sf: result_sf, to: 1'b0});
            if (timed)   exp_rsp.push_back('{due: cyc + 1, r: r, op: 3'd0, sf: 2'd0, to: 1'b1});
            if (matched || timed) begin
                m_pend[r] = 1'b0;
                m_seq[r]  = m_seq[r] + 2'd1;
            end
        end
        if (g >= 0) begin
            exp_chk.push_back('{due: cyc + 1, mac: mac_of[g], id: {m_seq[g], 2'(g)}});
            m_pend[g]    = 1'b1;
            m_chk_cyc[g] = cyc + 1;
            m_rr         = (g + 1) % 4;
            if (!drop_mask[g] && ($urandom_range(99) >= 32'(drop_pct)))
                inject(cyc + 3, {m_seq[g], 2'(g)}, 3'($urandom), 2'($urandom));
            req_valid[g] = 1'b0;
        end
    endtask

    task automatic run(int n);
        int g;
        repeat (n) step(g);
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_check_valid"}, 64'(check_valid), 64'd0);
        check({tag, "_check_mac"},   64'(check_mac),   64'd0);
        check({tag, "_check_id"},    64'(check_id),    64'd0);
        check({tag, "_rsp_valid"},   64'(rsp_valid),   64'd0);
        check({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
        check({tag, "_rsp_outport"}, 64'(rsp_outport), 64'd0);
        check({tag, "_rsp_seek"},    64'(rsp_seek),    64'd0);
    endtask

    // Reset in the middle of a cycle; outputs must clear without a clock edge.
    task automatic apply_reset();
        @(negedge clk);
        req_valid_in = 4'd0;
        result_valid = 1'b0;
        req_valid    = 4'd0;
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares registered DUT outputs with expectations due this cycle.
    logic       mon_cv;
    logic [3:0] mon_mask;
    logic [3:0] mon_to;
    logic [2:0] mon_op [4];
    logic [1:0] mon_sf [4];
    int         mon_r;

    always begin
        @(negedge clk);
        #2;
        mon_cv = (exp_chk.size() > 0) && (exp_chk[0].due == cyc);
        check("check_valid", 64'(check_valid), 64'(mon_cv));
        if (mon_cv) begin
            check("check_mac", 64'(check_mac), 64'(exp_chk[0].mac));
            check("check_id",  64'(check_id),  64'(exp_chk[0].id));
            void'(exp_chk.pop_front());
        end
        mon_mask = 4'd0;
        mon_to   = 4'd0;
        while (exp_rsp.size() > 0 && exp_rsp[0].due == cyc) begin
            mon_r = exp_rsp[0].r;
            mon_mask[mon_r] = 1'b1;
            mon_to[mon_r]   = exp_rsp[0].to;
            mon_op[mon_r]   = exp_rsp[0].op;
            mon_sf[mon_r]   = exp_rsp[0].sf;
            void'(exp_rsp.pop_front());
        end
        check("rsp_valid",   64'(rsp_valid),   64'(mon_mask));
        check("rsp_timeout", 64'(rsp_timeout), 64'(mon_to));
        for (int r = 0; r < 4; r++) begin
            if (mon_mask[r]) begin
                check("rsp_outport", 64'(rsp_outport[3*r +: 3]), 64'(mon_op[r]));
                check("rsp_seek",    64'(rsp_seek[2*r +: 2]),    64'(mon_sf[r]));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int tc;
        req_valid    = 4'd0;
        req_valid_in = 4'd0;
        req_mac_in   = '0;
        result_valid = 1'b0;
        result_id    = 4'd0;
        result_op    = 3'd0;
        result_sf    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            mac_of[i]    = 48'd0;
            drop_mask[i] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("reset_ready", 64'(ready), 64'd0);
        rst_n = 1'b1;

        // 1: single request, hand-built result (outport 0, seek CROSSBAR)
        drop_mask[0] = 1'b1;
        mac_of[0]    = 48'h8DBC5C4A0102;
        req_valid    = 4'b0001;
        step(g);
        tc = cyc;
        inject(tc + 3, 4'b0000, 3'd0, 2'd1);
        run(6);
        drop_mask[0] = 1'b0;
        mac_of[0]    = 48'h0000_1111_2222;
        req_valid    = 4'b0001;
        run(8);

        // 2: all four requesting continuously from reset
        apply_reset();
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i]) begin
                    req_valid[i] = 1'b1;
                    mac_of[i]    = 48'({$urandom, $urandom});
                end
            end
            step(g);
        end
        req_valid = 4'd0;
        run(8);

        // 3: req 2 never answered -> timeout, then a late result is dropped
        drop_mask[2] = 1'b1;
        mac_of[2]    = 48'hA5A5_0000_0002;
        req_valid    = 4'b0100;
        step(g);
        run(P_TO + 6);
        inject(cyc + 1, 4'b0010, 3'd5, 2'd3);
        run(4);
        drop_mask[2] = 1'b0;

        // 4: result for req 1 arrives in its timeout cycle -> normal response
        drop_mask[1] = 1'b1;
        req_valid    = 4'b0010;
        step(g);
        tc = cyc;
        inject(tc + 1 + P_TO - 1, {m_seq[1], 2'b01}, 3'd6, 2'd2);
        run(P_TO + 4);
        drop_mask[1] = 1'b0;

        // 5: result for idle req 3 is dropped
        inject(cyc + 1, 4'b0011, 3'd7, 2'd3);
        run(3);

        // 6: reset while req 0 pending; later result ignored; rr restarts at 0
        drop_mask[0] = 1'b1;
        req_valid    = 4'b0001;
        step(g);
        run(1);
        apply_reset();
        drop_mask[0] = 1'b0;
        inject(cyc + 1, 4'b0000, 3'd3, 2'd1);
        run(3);
        req_valid = 4'b1111;
        run(12);
        req_valid = 4'd0;
        run(8);

        // Randomized traffic with dropped and stray results
        drop_pct = 12;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && ($urandom_range(3) == 0)) begin
                    req_valid[i] = 1'b1;
                    mac_of[i]    = 48'({$urandom, $urandom});
                end
            end
            if (($urandom_range(9) == 0) && !sched_busy(cyc + 1))
                inject(cyc + 1, 4'($urandom), 3'($urandom), 2'($urandom));
            step(g);
        end
        drop_pct  = 0;
        req_valid = 4'd0;
        run(P_TO + 10);
        @(negedge clk);
        #3;
        check("drain_chk_queue", 64'(exp_chk.size()), 64'd0);
        check("drain_rsp_queue", 64'(exp_rsp.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
